alarm_unit: RTL
===============

ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  TONE_HALF, 25000: clk cycles per buzzer tone half-period (1 kHz at 50 MHz).
  BEEP_HALF, 12500000: clk cycles per beep on/off half-period (0.25 s).
  RING_SEC, 30: seconds of ringing before auto-stop.
  SNOOZE_SEC, 300: seconds of snooze before re-ring.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  system clock, 50 MHz.
  rst  in  1  synchronous, active-high reset.
  i_sec  in  6  current clock seconds, 0-59, from the min/sec counter.
  i_min  in  6  current clock minutes, 0-59.
  i_set_en  in  1  level; 1 = alarm-time setup active.
  i_pos  in  1  setup field; 0 = seconds, 1 = minutes.
  i_inc  in  1  one-cycle pulse; increment the selected alarm field.
  i_arm  in  1  one-cycle pulse; toggle armed/disarmed.
  i_stop  in  1  one-cycle pulse; stop ringing or snooze.
  i_snooze  in  1  one-cycle pulse; snooze while ringing.
  o_alarm_sec  out  6  alarm seconds, 0-59, for the display path.
  o_alarm_min  out  6  alarm minutes, 0-59.
  o_state  out  2  FSM state: 00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE.
  o_buzz  out  1  buzzer drive.
REQ-003 All outputs SHALL be registered on posedge clk.

Function
REQ-004 The block SHALL register i_sec every cycle. It SHALL assert internal sec_tick for exactly one cycle whenever i_sec differs from its registered copy.
REQ-005 The match condition SHALL be: sec_tick=1 AND i_sec==o_alarm_sec AND i_min==o_alarm_min.
REQ-006 When i_set_en=1, state is IDLE or ARMED, and i_inc=1, the block SHALL increment the field selected by i_pos by 1 on the next edge.
  59 SHALL wrap to 0.
  The unselected field SHALL be unchanged.
REQ-007 i_inc SHALL be ignored when i_set_en=0 or when state is RINGING or SNOOZE.
REQ-008 IDLE transitions: i_arm -> ARMED; all other inputs are ignored.
REQ-009 ARMED transitions: i_arm -> IDLE; otherwise, match -> RINGING.
  If i_arm and match occur in the same cycle, i_arm wins.
REQ-010 RINGING transitions, highest priority first: i_arm -> IDLE; i_stop -> ARMED; i_snooze -> SNOOZE; ring_cnt==RING_SEC-1 with sec_tick -> ARMED.
REQ-011 SNOOZE transitions, highest priority first: i_arm -> IDLE; i_stop -> ARMED; snz_cnt==SNOOZE_SEC-1 with sec_tick -> RINGING.
REQ-012 ring_cnt and snz_cnt SHALL clear to 0 on entry to their state, and increment on sec_tick while in that state.
  Their width SHALL be sized by $clog2 of the respective parameter.
REQ-013 While RINGING, o_buzz SHALL equal beep_gate AND tone.
  tone toggles every TONE_HALF cycles.
  beep_gate toggles every BEEP_HALF cycles.
  On RINGING entry, both SHALL reload to 1 and their counters SHALL reload to 0, so o_buzz=1 on the first RINGING cycle.
REQ-014 o_buzz SHALL be 0 in all other states, on the cycle of state exit.
REQ-015 Changes to i_set_en or i_pos SHALL NOT affect the FSM.
REQ-016 Simultaneous i_stop and i_snooze in RINGING SHALL resolve to ARMED.

Reset
REQ-017 When rst=1 at posedge clk, the block SHALL set: state IDLE; o_alarm_sec=0; o_alarm_min=0; o_buzz=0; all counters 0; the registered i_sec copy = i_sec.
  The last item prevents a sec_tick on the first cycle after reset.
REQ-018 Reset SHALL take effect from any state, including mid-ring, and SHALL override every input in the same cycle.

Verification
Benches SHALL use TONE_HALF=2, BEEP_HALF=8, RING_SEC=3, SNOOZE_SEC=2.
REQ-019 Set-and-wrap: i_set_en=1, i_pos=0, 60 i_inc pulses -> o_alarm_sec returns to 0. Then i_pos=1, 5 pulses -> o_alarm_min=5 and o_alarm_sec=0.
REQ-020 Match and auto-stop: alarm 01:10, armed, drive i_min=1 with i_sec stepping 9 -> 10.
  -> o_state=10 the cycle after i_sec becomes 10.
  -> o_buzz pattern 1,1,0,0,... gated off after 8 cycles.
  -> o_state=01 on the 3rd subsequent sec_tick.
REQ-021 Snooze: in RINGING pulse i_snooze -> o_state=11, o_buzz=0. After 2 sec_ticks -> o_state=10 with o_buzz=1.
REQ-022 Priority: in ARMED apply i_arm in the same cycle as match -> o_state=00, no ringing. In RINGING apply i_stop+i_snooze together -> o_state=01.
REQ-023 No retrigger: stop during 01:10, hold i_sec=10 for 100 cycles -> stays 01. Also i_inc with i_set_en=1 during RINGING -> alarm time unchanged.
REQ-024 Reset mid-ring: rst=1 for one cycle while RINGING -> next cycle o_state=00, o_buzz=0, alarm time 00:00.

Source files
------------

// File: rtl/alarm_unit.sv
// alarm_unit: alarm-time register, arm/ring/snooze state machine and a
// beep-gated buzzer tone, all outputs registered.
module alarm_unit #(
  parameter int TONE_HALF  = 25000,
  parameter int BEEP_HALF  = 12500000,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic       i_set_en,
  input  logic       i_pos,
  input  logic       i_inc,
  input  logic       i_arm,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic [5:0] o_alarm_sec,
  output logic [5:0] o_alarm_min,
  output logic [1:0] o_state,
  output logic       o_buzz
);

  localparam int TW = (TONE_HALF  > 1) ? $clog2(TONE_HALF)  : 1;
  localparam int BW = (BEEP_HALF  > 1) ? $clog2(BEEP_HALF)  : 1;
  localparam int RW = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
  localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } state_t;

  state_t        state;
  logic [5:0]    sec_q;
  logic          sec_tick;
  logic          match;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [TW-1:0] tone_cnt;
  logic [TW-1:0] tone_cnt_nx;
  logic [BW-1:0] beep_cnt;
  logic [BW-1:0] beep_cnt_nx;
  logic          tone;
  logic          tone_nx;
  logic          gate;
  logic          gate_nx;

  assign sec_tick = (i_sec != sec_q);
  assign match    = sec_tick && (i_sec == o_alarm_sec) && (i_min == o_alarm_min);
  assign o_state  = state;

  // Next tone / beep-gate phase while the alarm keeps ringing
  always_comb begin
    tone_cnt_nx = tone_cnt;
    tone_nx     = tone;
    beep_cnt_nx = beep_cnt;
    gate_nx     = gate;
    if (tone_cnt == TW'(TONE_HALF - 1)) begin
      tone_cnt_nx = '0;
      tone_nx     = ~tone;
    end else begin
      tone_cnt_nx = tone_cnt + TW'(1);
    end
    if (beep_cnt == BW'(BEEP_HALF - 1)) begin
      beep_cnt_nx = '0;
      gate_nx     = ~gate;
    end else begin
      beep_cnt_nx = beep_cnt + BW'(1);
    end
  end

  // Seconds edge detector and alarm-time setup (locked while ringing/snoozing)
  always_ff @(posedge clk) begin
    sec_q <= i_sec;
    if (rst) begin
      o_alarm_sec <= 6'd0;
      o_alarm_min <= 6'd0;
    end else if (i_set_en && i_inc && ((state == IDLE) || (state == ARMED))) begin
      if (i_pos) begin
        o_alarm_min <= (o_alarm_min == 6'd59) ? 6'd0 : o_alarm_min + 6'd1;
      end else begin
        o_alarm_sec <= (o_alarm_sec == 6'd59) ? 6'd0 : o_alarm_sec + 6'd1;
      end
    end
  end

  // Alarm state machine with ring/snooze timers and buzzer drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      tone_cnt <= '0;
      beep_cnt <= '0;
      tone     <= 1'b0;
      gate     <= 1'b0;
      o_buzz   <= 1'b0;
    end else begin
      o_buzz <= 1'b0;
      case (state)
        IDLE: begin
          if (i_arm) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (i_arm) begin
            state <= IDLE;
          end else if (match) begin
            state    <= RINGING;
            ring_cnt <= '0;
            tone_cnt <= '0;
            beep_cnt <= '0;
            tone     <= 1'b1;
            gate     <= 1'b1;
            o_buzz   <= 1'b1;
          end
        end
        RINGING: begin
          if (i_arm) begin
            state <= IDLE;
          end else if (i_stop) begin
            state <= ARMED;
          end else if (i_snooze) begin
            state   <= SNOOZE;
            snz_cnt <= '0;
          end else if (sec_tick && (ring_cnt == RW'(RING_SEC - 1))) begin
            state <= ARMED;
          end else begin
            if (sec_tick) begin
              ring_cnt <= ring_cnt + RW'(1);
            end
            tone_cnt <= tone_cnt_nx;
            beep_cnt <= beep_cnt_nx;
            tone     <= tone_nx;
            gate     <= gate_nx;
            o_buzz   <= tone_nx & gate_nx;
          end
        end
        SNOOZE: begin
          if (i_arm) begin
            state <= IDLE;
          end else if (i_stop) begin
            state <= ARMED;
          end else if (sec_tick && (snz_cnt == SW'(SNOOZE_SEC - 1))) begin
            state    <= RINGING;
            ring_cnt <= '0;
            tone_cnt <= '0;
            beep_cnt <= '0;
            tone     <= 1'b1;
            gate     <= 1'b1;
            o_buzz   <= 1'b1;
          end else if (sec_tick) begin
            snz_cnt <= snz_cnt + SW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
